// File: rtl/ecc_sed_encoder_pipe_pkg.sv
// Shared definitions for the SED encoder pipe: counter width and the
// per-group parity helper used to build codewords.
package ecc_sed_pkg;

  localparam int CNT_W     = 16;
  // Upper bound on payload width the parity helper handles.
  localparam int SED_MAX_W = 256;

  // Parity vector for a payload split into 'lanes' equal groups of
  // data_w/lanes bits. Bit i covers data[i*G +: G]; 'odd' flips every bit
  // so each group plus its parity bit carries an odd number of ones.
  function automatic logic [SED_MAX_W-1:0] sed_parity(
    input logic [SED_MAX_W-1:0] data,
    input int                   lanes,
    input logic                 odd,
    input int                   data_w
  );
    logic [SED_MAX_W-1:0] p;
    int                   g;
    p = '0;
    g = data_w / lanes;
    for (int j = 0; j < SED_MAX_W; j++) begin
      if (j < data_w) begin
        p[j / g] = p[j / g] ^ data[j];
      end
    end
    for (int i = 0; i < SED_MAX_W; i++) begin
      if (i < lanes) begin
        p[i] = p[i] ^ odd;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ecc_sed_encoder_pipe_skid.sv
// Generic two-slot valid/ready skid stage. OUT is the registered output
// slot, SKID catches one word when OUT is stalled. Words leave in order.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both 1. A source holding valid keeps its data stable until that edge;
// o_out_valid/o_out_data never change while o_out_valid & ~i_out_ready.
// o_in_ready is a function of registered state and rst only.
module ecc_sed_skid #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;
  logic         w_acc;
  logic         w_drain;

  assign o_in_ready  = rst & ~r_skid_valid;
  assign w_acc       = i_in_valid & o_in_ready;
  assign w_drain     = r_out_valid & i_out_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;

  // Slot update: refill OUT from SKID first, else from the input; park the
  // input in SKID only when OUT is full and holding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else begin
      if (!r_out_valid || w_drain) begin
        if (r_skid_valid) begin
          // SKID full means input ready was low, so nothing new arrives.
          r_out_data   <= r_skid_data;
          r_out_valid  <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (w_acc) begin
          r_out_data  <= i_in_data;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid_data  <= i_in_data;
        r_skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecc_sed_encoder_pipe.sv
// Pipelined single-error-detect encoder: one parity bit per data group,
// codeword {parity, data} leaves through a registered skid stage.
// Optional macro ECC_SED_ERR_INJECT_EN adds inj_req/inj_done, which invert
// parity[0] of the next accepted word for error-path testing.
module ecc_sed_encoder_pipe
  import ecc_sed_pkg::*;
#(
  parameter int DATA_W     = 12,
  parameter int LANES      = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic [DATA_W-1:0]       data,
  output logic                    enc_valid,
  input  logic                    enc_ready,
  output logic [DATA_W+LANES-1:0] enc_codeword,
  output logic [CNT_W-1:0]        word_cnt
`ifdef ECC_SED_ERR_INJECT_EN
  ,
  input  logic                    inj_req,
  output logic                    inj_done
`endif
);

  logic [LANES-1:0]        w_parity;
  logic [LANES-1:0]        w_parity_out;
  logic [DATA_W+LANES-1:0] w_codeword;
  logic [CNT_W-1:0]        r_word_cnt;

  // Encoding is done on the input side so a stalled word never changes.
  assign w_parity   = LANES'(sed_parity(SED_MAX_W'(data), LANES, ODD_PARITY != 0, DATA_W));
  assign w_codeword = {w_parity_out, data};

`ifdef ECC_SED_ERR_INJECT_EN
  logic w_acc;
  logic w_inj_apply;
  logic r_inj_pend;
  logic r_inj_done;

  assign w_acc        = data_valid & data_ready;
  // A request in the accepting cycle counts even when nothing is pending.
  assign w_inj_apply  = w_acc & (r_inj_pend | inj_req);
  assign w_parity_out = w_parity ^ LANES'(w_inj_apply);
  assign inj_done     = r_inj_done;

  // Pending flag collapses repeated requests; cleared by the injected word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_inj_pend <= 1'b0;
      r_inj_done <= 1'b0;
    end else begin
      r_inj_done <= w_inj_apply;
      if (w_acc) begin
        r_inj_pend <= 1'b0;
      end else if (inj_req) begin
        r_inj_pend <= 1'b1;
      end
    end
  end
`else
  assign w_parity_out = w_parity;
`endif

  ecc_sed_skid #(
    .W (DATA_W + LANES)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (data_valid),
    .o_in_ready  (data_ready),
    .i_in_data   (w_codeword),
    .o_out_valid (enc_valid),
    .i_out_ready (enc_ready),
    .o_out_data  (enc_codeword)
  );

  assign word_cnt = r_word_cnt;

  // Count output handshakes; natural wrap at the counter width.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word_cnt <= '0;
    end else if (enc_valid && enc_ready) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ecc_sed_encoder_pipe.sv
// Bench for ecc_sed_encoder_pipe: three instances (LANES=1 even, LANES=3
// even, LANES=1 odd) share stimulus and are checked against a FIFO model
// every cycle, plus hand-computed codeword literals.
module tb_ecc_sed_encoder_pipe;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus / DUT wiring ----------------
  logic        data_valid;
  logic [11:0] data;
  logic        enc_ready;
  logic        inj_req;

  logic        ready_a, ready_b, ready_c;
  logic        valid_a, valid_b, valid_c;
  logic [12:0] cw_a;
  logic [14:0] cw_b;
  logic [12:0] cw_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic        done_a, done_b, done_c;

  ecc_sed_encoder_pipe #(.DATA_W(12), .LANES(1), .ODD_PARITY(0)) u_dut_a (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(ready_a),
    .data(data), .enc_valid(valid_a), .enc_ready(enc_ready),
    .enc_codeword(cw_a), .word_cnt(cnt_a)
`ifdef ECC_SED_ERR_INJECT_EN
    , .inj_req(inj_req), .inj_done(done_a)
`endif
  );

  ecc_sed_encoder_pipe #(.DATA_W(12), .LANES(3), .ODD_PARITY(0)) u_dut_b (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(ready_b),
    .data(data), .enc_valid(valid_b), .enc_ready(enc_ready),
    .enc_codeword(cw_b), .word_cnt(cnt_b)
`ifdef ECC_SED_ERR_INJECT_EN
    , .inj_req(inj_req), .inj_done(done_b)
`endif
  );

  ecc_sed_encoder_pipe #(.DATA_W(12), .LANES(1), .ODD_PARITY(1)) u_dut_c (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(ready_c),
    .data(data), .enc_valid(valid_c), .enc_ready(enc_ready),
    .enc_codeword(cw_c), .word_cnt(cnt_c)
`ifdef ECC_SED_ERR_INJECT_EN
    , .inj_req(inj_req), .inj_done(done_c)
`endif
  );

`ifndef ECC_SED_ERR_INJECT_EN
  assign done_a = 1'b0;
  assign done_b = 1'b0;
  assign done_c = 1'b0;
`endif

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Codeword from first principles: count ones per group, parity makes
  // group+bit even (or odd), optional inversion of parity[0].
  function automatic logic [15:0] exp_cw(input logic [11:0] d, input int lanes,
                                         input int odd, input bit inj);
    logic [15:0] p;
    int          g;
    int          ones;
    p = '0;
    g = 12 / lanes;
    for (int i = 0; i < lanes; i++) begin
      ones = 0;
      for (int b = 0; b < g; b++) ones += int'(d[i*g+b]);
      p[i] = ((ones + odd) % 2) == 1;
    end
    if (inj) p[0] = ~p[0];
    return (p << 12) | 16'(d);
  endfunction

  // ---------------- behavioural model ----------------
  // The block behaves as a 2-deep FIFO: accept when fewer than two words
  // are held, present the oldest word, pop on enc_ready.
  logic [12:0] exp_q[$];   // {inject flag, data}
  logic [15:0] m_cnt  = '0;
  bit          m_pend = 1'b0;
  bit          m_done = 1'b0;
  bit          m_acc, m_drn, m_inj;

  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_cnt  = '0;
      m_pend = 1'b0;
      m_done = 1'b0;
    end else begin
      m_acc = data_valid && (exp_q.size() < 2);
      m_drn = enc_ready && (exp_q.size() > 0);
      m_inj = 1'b0;
`ifdef ECC_SED_ERR_INJECT_EN
      m_inj  = m_acc && (m_pend || inj_req);
      m_pend = m_acc ? 1'b0 : (m_pend || inj_req);
`endif
      m_done = m_inj;
      if (m_drn) begin
        void'(exp_q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (m_acc) exp_q.push_back({m_inj, data});
    end
  end

  task automatic cmp_dut(input string tag, input logic rdy, input logic vld,
                         input logic [15:0] cw, input logic [15:0] cnt,
                         input logic done, input int lanes, input int odd);
    check({tag, "_ready"}, 32'(rdy), 32'(rst && (exp_q.size() < 2)));
    check({tag, "_valid"}, 32'(vld), 32'(exp_q.size() > 0));
    check({tag, "_cnt"}, 32'(cnt), 32'(m_cnt));
    if (exp_q.size() > 0)
      check({tag, "_cw"}, 32'(cw), 32'(exp_cw(exp_q[0][11:0], lanes, odd, exp_q[0][12])));
`ifdef ECC_SED_ERR_INJECT_EN
    check({tag, "_inj_done"}, 32'(done), 32'(m_done));
`else
    if (done) check({tag, "_done_tie"}, 32'(done), 32'(0));
`endif
  endtask

  // Compare process: every falling edge once the bench has left time zero.
  always @(negedge clk) begin
    if (started) begin
      cmp_dut("a", ready_a, valid_a, 16'(cw_a), cnt_a, done_a, 1, 0);
      cmp_dut("b", ready_b, valid_b, 16'(cw_b), cnt_b, done_b, 3, 0);
      cmp_dut("c", ready_c, valid_c, 16'(cw_c), cnt_c, done_c, 1, 1);
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs, let one rising edge consume them, settle 2 time units.
  task automatic step(input logic v, input logic [11:0] d, input logic r);
    data_valid = v;
    data       = d;
    enc_ready  = r;
    @(posedge clk);
    #2;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b0;
    data_valid = 1'b0;
    data       = '0;
    enc_ready  = 1'b0;
    inj_req    = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    started = 1'b1;

    // Reset state
    check("rst_valid", 32'(valid_a), 32'(0));
    check("rst_cw", 32'(cw_a), 32'(0));
    check("rst_cnt", 32'(cnt_a), 32'(0));
    check("rst_ready_low", 32'(ready_a), 32'(0));
    rst = 1'b1;
    #1;
    check("ready_after_rst", 32'(ready_a), 32'(1));

    // Literal codewords, consumer always ready
    step(1'b1, 12'h001, 1'b1);
    check("lit_a_001", 32'(cw_a), 32'h1001);
    check("lit_c_001", 32'(cw_c), 32'h0001);
    check("lit_valid", 32'(valid_a), 32'(1));
    step(1'b1, 12'h003, 1'b1);
    check("lit_a_003", 32'(cw_a), 32'h0003);
    step(1'b1, 12'h0F1, 1'b1);
    check("lit_b_0f1", 32'(cw_b), 32'h10F1);
    step(1'b1, 12'h000, 1'b1);
    check("lit_c_000", 32'(cw_c), 32'h1000);
    step(1'b0, 12'h000, 1'b1);
    check("lit_drained", 32'(valid_a), 32'(0));
    check("lit_cnt4", 32'(cnt_a), 32'(4));

    // Back-pressure
    step(1'b1, 12'h0A1, 1'b0);
    step(1'b1, 12'h0A2, 1'b0);
    check("bp_ready_low", 32'(ready_a), 32'(0));
    check("bp_cw_a1", 32'(cw_a), 32'h10A1);
    step(1'b1, 12'h0A3, 1'b0);
    check("bp_cw_stable", 32'(cw_a), 32'h10A1);
    step(1'b0, 12'h000, 1'b1);
    check("bp_cw_a2", 32'(cw_a), 32'h10A2);
    check("bp_ready_back", 32'(ready_a), 32'(1));
    step(1'b0, 12'h000, 1'b1);
    check("bp_empty", 32'(valid_a), 32'(0));
    check("bp_cnt6", 32'(cnt_a), 32'(6));

    // Reset while both slots are full
    step(1'b1, 12'h0B1, 1'b0);
    step(1'b1, 12'h0B2, 1'b0);
    check("stall_full", 32'(ready_a), 32'(0));
    rst = 1'b0;
    step(1'b0, 12'h000, 1'b1);
    check("mid_rst_valid", 32'(valid_a), 32'(0));
    check("mid_rst_cnt", 32'(cnt_a), 32'(0));
    check("mid_rst_cw", 32'(cw_a), 32'(0));
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(ready_a), 32'(1));
    step(1'b0, 12'h000, 1'b1);
    check("mid_rst_no_out", 32'(valid_a), 32'(0));

`ifdef ECC_SED_ERR_INJECT_EN
    // Error injection on the next accepted word only
    inj_req = 1'b1;
    step(1'b0, 12'h000, 1'b1);
    inj_req = 1'b0;
    step(1'b1, 12'h001, 1'b1);
    check("inj_cw", 32'(cw_a), 32'h0001);
    check("inj_done_hi", 32'(done_a), 32'(1));
    step(1'b1, 12'h001, 1'b1);
    check("inj_after_cw", 32'(cw_a), 32'h1001);
    check("inj_done_lo", 32'(done_a), 32'(0));
    step(1'b0, 12'h000, 1'b1);
`endif

    // Randomized traffic with sporadic reset and back-pressure
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
`ifdef ECC_SED_ERR_INJECT_EN
      inj_req = ($urandom_range(0, 9) == 0);
`endif
      step($urandom_range(0, 9) < 6, 12'($urandom), $urandom_range(0, 9) < 7);
    end
    rst = 1'b1;
    inj_req = 1'b0;
    repeat (4) step(1'b0, 12'h000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_sed_encoder_pipe.md
# ecc_sed_encoder_pipe

Parametrised, pipelined single-error-detect (SED) encoder. It splits a DATA_W-bit word into LANES equal groups, computes one parity bit per group, and emits {parity, data} through a registered valid/ready output stage with a skid buffer. It sits between a producer and any stalling consumer on the ECC write path, and replaces the fixed 12-bit combinational encoder where back-pressure or per-lane parity is needed.

## Interface
- DATA_W, 12, payload width; must be divisible by LANES.
- LANES, 1, number of parity groups; group width G = DATA_W/LANES.
- ODD_PARITY, 0, 0 = even parity per group, 1 = odd parity.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset (low at posedge = reset).
- data_valid  in  1  input word valid.
- data_ready  out  1  block can accept a word.
- data  in  DATA_W  payload.
- enc_valid  out  1  codeword valid.
- enc_ready  in  1  consumer accepts codeword.
- enc_codeword  out  DATA_W+LANES  {parity[LANES-1:0], data}.
- word_cnt  out  16  count of output handshakes, wrapping.
- inj_req  in  1  error-inject request (present only with ECC_SED_ERR_INJECT_EN).
- inj_done  out  1  1-cycle pulse when an injected word is accepted on the input (present only with ECC_SED_ERR_INJECT_EN).

## Operation
- parity[i] = XOR(data[i*G +: G]) ^ ODD_PARITY. The codeword group plus its parity bit has an even number of ones (odd when ODD_PARITY=1).
- Input handshake: data_valid & data_ready. Output handshake: enc_valid & enc_ready.
- Two storage slots: output register (OUT) and skid register (SKID). Words leave in strict arrival order.
- Accept with OUT empty, or with OUT draining this cycle and SKID empty: the word loads OUT.
- Accept while OUT is full and not draining: the word loads SKID.
- OUT drains with SKID full: SKID moves to OUT, and SKID is then empty.
- data_ready = ~SKID_valid. It is 0 while rst is low.
- Encoding happens at input acceptance. The stored codeword does not change while it is stalled.
- word_cnt increments on every output handshake and wraps from 0xFFFF to 0x0000.
- Simultaneous input accept and output drain with SKID empty: OUT takes the new word. Throughput is 1 word per cycle.

## Timing
- Latency: a word accepted at edge N is on enc_codeword with enc_valid=1 after edge N. Combinationally, it is visible in the cycle following acceptance.
- Reset values: enc_valid=0, enc_codeword=0, word_cnt=0, SKID empty, inj_done=0, inject pending flag=0.
- Reset mid-transfer discards OUT and SKID contents. No partial output is produced.
- data_ready is 1 in the first cycle after rst returns high.
- enc_valid must not drop and enc_codeword must not change until the output handshake completes.
- No combinational path from enc_ready to data_ready. data_ready depends only on registered state and rst.

## Configuration
- Macro: ECC_SED_ERR_INJECT_EN.
- Defined:
  - inj_req=1 at an edge sets a pending flag.
  - The next input-accepted word has parity[0] inverted.
  - The pending flag clears at that acceptance, and inj_done pulses for 1 cycle.
  - inj_req arriving in the same cycle as an acceptance with no flag pending applies to that word.
  - Repeated requests while the flag is pending collapse into one injection.
- Undefined: inj_req and inj_done ports are absent, and parity is never altered.

## Structure
- Package ecc_sed_pkg holds:
  - the function sed_parity(data, lanes, odd) returning the LANES-bit parity vector;
  - the localparam CNT_W = 16.
- Sub-module ecc_sed_skid: generic 2-slot valid/ready skid stage parametrised by width. The encoder computes the codeword and feeds it to ecc_sed_skid.

## Test plan
- DATA_W=12, LANES=1, even, enc_ready=1: data 0x001 -> enc_codeword 0x1001 one cycle later. Data 0x003 -> 0x0003.
- DATA_W=12, LANES=3 (G=4), even: data 0x0F1 -> parity 3'b001, enc_codeword 15'h10F1.
- ODD_PARITY=1, LANES=1: data 0x000 -> enc_codeword 0x1000.
- Back-pressure:
  - hold enc_ready=0 and send 0x0A1 then 0x0A2 -> data_ready=0 after the second word, and enc_codeword stays stable;
  - raise enc_ready -> outputs in order 0x0A1 then 0x0A2, no loss or duplication;
  - word_cnt = 2 at the end.
- Reset mid-stall: both slots full, rst low for 1 edge -> enc_valid=0, word_cnt=0, data_ready=1 on the next cycle. Neither stored word is ever output.
- With ECC_SED_ERR_INJECT_EN, LANES=1: pulse inj_req, then send 0x001 -> enc_codeword 0x0001 and inj_done pulses once. The following word 0x001 -> 0x1001.
